// File: rtl/present_pkg.sv
// Shared types and constants for the presents subsystem.
package present_pkg;

  typedef enum logic [1:0] {
    PRESENT_LIFE   = 2'd0,
    PRESENT_FREEZE = 2'd1,
    PRESENT_SHIELD = 2'd2,
    PRESENT_ROPE   = 2'd3
  } present_type_t;

  localparam int unsigned EFFECT_TIMER_W = 10;
  localparam int unsigned FRAME_RATE     = 60;

endpackage

// File: rtl/present_effect_manager_if.sv
// Bundle between the presents controller / game logic and the effect manager.
interface present_effect_manager_if;
  import present_pkg::*;

  logic          startOfFrame;
  logic          gameActive;
  logic          col_present;
  present_type_t present_type;
  logic          addLife;
  logic          freezeBalls;
  logic          shieldActive;
  logic          fastRope;
  logic          effectWarning;

  // Game-side driver of the frame strobe, game state and pickup events.
  modport master (
    output startOfFrame,
    output gameActive,
    output col_present,
    output present_type,
    input  addLife,
    input  freezeBalls,
    input  shieldActive,
    input  fastRope,
    input  effectWarning
  );

  // The effect manager itself.
  modport slave (
    input  startOfFrame,
    input  gameActive,
    input  col_present,
    input  present_type,
    output addLife,
    output freezeBalls,
    output shieldActive,
    output fastRope,
    output effectWarning
  );

endinterface

// File: rtl/effect_timer.sv
// Frame-counted effect timer: clear > load > tick > hold, saturating at 0.
module effect_timer
  import present_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 1,
  parameter int unsigned WARN_VAL = 0
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic load,
  input  logic tick,
  output logic active,
  output logic warn
);

  localparam logic [EFFECT_TIMER_W-1:0] LoadCnt = EFFECT_TIMER_W'(LOAD_VAL);
  localparam logic [EFFECT_TIMER_W-1:0] WarnCnt = EFFECT_TIMER_W'(WARN_VAL);

  logic [EFFECT_TIMER_W-1:0] count_q, count_d;
  logic                      active_q, active_d;
  logic                      warn_q, warn_d;

  // Next count by priority; flags derive from the next count so they stay aligned with it.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = LoadCnt;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
    active_d = (count_d != '0);
    warn_d   = active_d && (count_d <= WarnCnt);
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q  <= '0;
      active_q <= 1'b0;
      warn_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      warn_q   <= warn_d;
    end
  end

  assign active = active_q;
  assign warn   = warn_q;

endmodule

// File: rtl/present_effect_manager.sv
// Turns present pickups into an extra-life pulse or frame-timed power-ups.
module present_effect_manager
  import present_pkg::*;
#(
  parameter int unsigned FREEZE_FRAMES = 180,
  parameter int unsigned SHIELD_FRAMES = 300,
  parameter int unsigned ROPE_FRAMES   = 240,
  parameter int unsigned WARN_FRAMES   = 60
) (
  input logic                     clk,
  input logic                     resetN,
  present_effect_manager_if.slave bus
);

  logic col_prev_q;
  logic add_life_q, add_life_d;
  logic collect;
  logic clear;
  logic load_freeze, load_shield, load_rope;
  logic warn_freeze, warn_shield, warn_rope;

  // A pickup is a rising edge of the overlap while a level is in play.
  always_comb begin
    collect     = bus.col_present && !col_prev_q && bus.gameActive;
    clear       = !bus.gameActive;
    add_life_d  = collect && (bus.present_type == PRESENT_LIFE);
    load_freeze = collect && (bus.present_type == PRESENT_FREEZE);
    load_shield = collect && (bus.present_type == PRESENT_SHIELD);
    load_rope   = collect && (bus.present_type == PRESENT_ROPE);
  end

  // Edge-detect history (tracks even while the game is inactive) and life pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      col_prev_q <= 1'b0;
      add_life_q <= 1'b0;
    end else begin
      col_prev_q <= bus.col_present;
      add_life_q <= add_life_d;
    end
  end

  effect_timer #(
    .LOAD_VAL (FREEZE_FRAMES),
    .WARN_VAL (WARN_FRAMES)
  ) u_freeze (
    .clk    (clk),
    .resetN (resetN),
    .clear  (clear),
    .load   (load_freeze),
    .tick   (bus.startOfFrame),
    .active (bus.freezeBalls),
    .warn   (warn_freeze)
  );

  effect_timer #(
    .LOAD_VAL (SHIELD_FRAMES),
    .WARN_VAL (WARN_FRAMES)
  ) u_shield (
    .clk    (clk),
    .resetN (resetN),
    .clear  (clear),
    .load   (load_shield),
    .tick   (bus.startOfFrame),
    .active (bus.shieldActive),
    .warn   (warn_shield)
  );

  effect_timer #(
    .LOAD_VAL (ROPE_FRAMES),
    .WARN_VAL (WARN_FRAMES)
  ) u_rope (
    .clk    (clk),
    .resetN (resetN),
    .clear  (clear),
    .load   (load_rope),
    .tick   (bus.startOfFrame),
    .active (bus.fastRope),
    .warn   (warn_rope)
  );

  assign bus.addLife       = add_life_q;
  assign bus.effectWarning = warn_freeze || warn_shield || warn_rope;

endmodule

// File: tb/tb_present_effect_manager.sv
// Bench: frame-level effect model checked every cycle, plus directed literal checks.
module tb_present_effect_manager;
  import present_pkg::*;

  localparam int FREEZE = 4;
  localparam int SHIELD = 5;
  localparam int ROPE   = 3;
  localparam int WARN   = 2;

  logic clk = 1'b0;
  logic resetN;
  int   total = 0;
  int   bad   = 0;

  present_effect_manager_if pif ();

  present_effect_manager #(
    .FREEZE_FRAMES (FREEZE),
    .SHIELD_FRAMES (SHIELD),
    .ROPE_FRAMES   (ROPE),
    .WARN_FRAMES   (WARN)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (pif.slave)
  );

  always #5 clk = ~clk;

  // Model state: remaining frames per effect (index = present type), last overlap, life pulse.
  int   m_left [4];
  logic m_prev;
  logic m_life;

  function automatic int frames_of(int t);
    case (t)
      1:       return FREEZE;
      2:       return SHIELD;
      3:       return ROPE;
      default: return 0;
    endcase
  endfunction

  initial begin
    foreach (m_left[i]) m_left[i] = 0;
    m_prev = 1'b0;
    m_life = 1'b0;
  end

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      foreach (m_left[i]) m_left[i] = 0;
      m_prev = 1'b0;
      m_life = 1'b0;
    end else begin
      bit picked;
      int t;
      picked = pif.col_present && !m_prev && pif.gameActive;
      t      = int'(pif.present_type);
      m_life = picked && (t == 0);
      for (int e = 1; e < 4; e++) begin
        if (!pif.gameActive)                m_left[e] = 0;
        else if (picked && t == e)          m_left[e] = frames_of(e);
        else if (pif.startOfFrame && m_left[e] > 0) m_left[e] = m_left[e] - 1;
      end
      m_prev = pif.col_present;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic w;
    w = 1'b0;
    for (int e = 1; e < 4; e++) if (m_left[e] > 0 && m_left[e] <= WARN) w = 1'b1;
    chk("model_addLife", pif.addLife, m_life);
    chk("model_freeze", pif.freezeBalls, m_left[1] > 0);
    chk("model_shield", pif.shieldActive, m_left[2] > 0);
    chk("model_rope", pif.fastRope, m_left[3] > 0);
    chk("model_warn", pif.effectWarning, w);
  end

  // Advance to 2 time units after the n-th following rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse();
    pif.startOfFrame = 1'b1;
    step(1);
    pif.startOfFrame = 1'b0;
    step(1);
  endtask

  task automatic pick(input present_type_t t);
    pif.present_type = t;
    pif.col_present  = 1'b1;
    step(1);
    pif.col_present  = 1'b0;
  endtask

  initial begin
    resetN           = 1'b0;
    pif.startOfFrame = 1'b0;
    pif.gameActive   = 1'b1;
    pif.col_present  = 1'b1;
    pif.present_type = PRESENT_LIFE;
    #12;
    chk("reset_addLife", pif.addLife, 1'b0);
    chk("reset_freeze", pif.freezeBalls, 1'b0);
    chk("reset_warn", pif.effectWarning, 1'b0);
    resetN = 1'b1;

    // 1: overlap already high at release counts as one pickup.
    step(1);
    chk("t1_life_pulse", pif.addLife, 1'b1);
    step(1);
    chk("t1_life_once", pif.addLife, 1'b0);
    step(2);
    chk("t1_life_held", pif.addLife, 1'b0);
    pif.col_present = 1'b0;
    step(1);

    // 2: freeze lasts exactly 4 strobes; 5th strobe does nothing.
    pick(PRESENT_FREEZE);
    chk("t2_freeze_rise", pif.freezeBalls, 1'b1);
    chk("t2_warn_at4", pif.effectWarning, 1'b0);
    step(1);
    pulse();
    chk("t2_warn_at3", pif.effectWarning, 1'b0);
    pulse();
    chk("t2_warn_at2", pif.effectWarning, 1'b1);
    pulse();
    chk("t2_freeze_at1", pif.freezeBalls, 1'b1);
    chk("t2_warn_at1", pif.effectWarning, 1'b1);
    pif.startOfFrame = 1'b1;
    step(1);
    pif.startOfFrame = 1'b0;
    chk("t2_freeze_fall", pif.freezeBalls, 1'b0);
    chk("t2_warn_at0", pif.effectWarning, 1'b0);
    step(1);
    pulse();
    chk("t2_fifth_pulse", pif.freezeBalls, 1'b0);

    // 3: re-collecting shield at count 2 reloads to 5 (no accumulation).
    pick(PRESENT_SHIELD);
    chk("t3_shield_rise", pif.shieldActive, 1'b1);
    step(1);
    repeat (3) pulse();
    chk("t3_warn_at2", pif.effectWarning, 1'b1);
    pick(PRESENT_SHIELD);
    chk("t3_reload_warn", pif.effectWarning, 1'b0);
    step(1);
    repeat (4) pulse();
    chk("t3_shield_after4", pif.shieldActive, 1'b1);
    pulse();
    chk("t3_shield_after5", pif.shieldActive, 1'b0);

    // 4: rope pickup coinciding with a strobe loads full; the tick is lost.
    pif.startOfFrame = 1'b1;
    pick(PRESENT_ROPE);
    pif.startOfFrame = 1'b0;
    chk("t4_rope_rise", pif.fastRope, 1'b1);
    chk("t4_warn_at3", pif.effectWarning, 1'b0);
    step(1);
    repeat (2) pulse();
    chk("t4_rope_after2", pif.fastRope, 1'b1);
    pulse();
    chk("t4_rope_after3", pif.fastRope, 1'b0);

    // 5: freeze warning is not masked by a longer-running shield.
    pick(PRESENT_FREEZE);
    step(1);
    pulse();
    pulse();
    pick(PRESENT_SHIELD);
    chk("t5_warn_f2_s5", pif.effectWarning, 1'b1);
    step(1);
    pulse();
    chk("t5_warn_f1_s4", pif.effectWarning, 1'b1);
    pulse();
    chk("t5_warn_f0_s3", pif.effectWarning, 1'b0);
    chk("t5_freeze_off", pif.freezeBalls, 1'b0);
    chk("t5_shield_on", pif.shieldActive, 1'b1);
    pulse();
    chk("t5_warn_s2", pif.effectWarning, 1'b1);

    // 6: game inactive clears effects and swallows pickups.
    pick(PRESENT_FREEZE);
    chk("t6_freeze_on", pif.freezeBalls, 1'b1);
    pif.gameActive = 1'b0;
    step(1);
    chk("t6_freeze_clr", pif.freezeBalls, 1'b0);
    chk("t6_shield_clr", pif.shieldActive, 1'b0);
    pif.present_type = PRESENT_LIFE;
    pif.col_present  = 1'b1;
    step(1);
    chk("t6_no_life", pif.addLife, 1'b0);
    pif.gameActive = 1'b1;
    step(1);
    chk("t6_no_replay", pif.addLife, 1'b0);
    step(1);
    chk("t6_no_replay2", pif.addLife, 1'b0);
    pif.col_present = 1'b0;
    step(1);

    // Asynchronous reset mid-effect clears outputs without a clock edge.
    pick(PRESENT_ROPE);
    chk("rst_rope_on", pif.fastRope, 1'b1);
    #1;
    resetN = 1'b0;
    #1;
    chk("rst_async_rope", pif.fastRope, 1'b0);
    step(2);
    resetN = 1'b1;
    step(2);
    chk("rst_after_rope", pif.fastRope, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
